add_checker: RTL and testbench
==============================

ADD_CHECKER -- requirements
Module: add_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width.
REQ-002 SHALL have parameter LAT, default 1, legal 1..4: adder result latency in clk cycles.
REQ-003 SHALL have parameter CNT_W, default 16: pass/fail counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset is synchronous and active-low.
REQ-006 SHALL have port valid_in  input  1  a/b presented to the adder this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH  operands driven to the adder.
REQ-008 SHALL have port c  input  WIDTH  adder result, sampled LAT cycles after the operands.
REQ-009 SHALL have port clr  input  1  synchronous clear of counters, err and capture regs.
REQ-010 SHALL have ports pass_cnt, fail_cnt  output  CNT_W  compare results.
REQ-011 SHALL have port err  output  1  sticky mismatch flag.
REQ-012 SHALL have ports exp_cap, got_cap  output  WIDTH  expected/actual values of the first mismatch.
REQ-013 SHALL have port state  output  2  current FSM state.

Function
REQ-014 SHALL compute expected = (a + b) mod 2^WIDTH; carry discarded, so 255+1 expects 0 at WIDTH=8.
REQ-015 SHALL delay {valid_in, expected} through an LAT-stage pipeline; comparison fires only when the delayed valid is 1.
REQ-016 SHALL skip bubbles (delayed valid 0): no count change, no compare.
REQ-017 SHALL run FSM IDLE(0) -> WARM(1) on first valid_in; WARM -> CHECK(2) when the first delayed valid emerges; CHECK -> HALT(3) only per REQ-027.
REQ-018 SHALL in CHECK increment pass_cnt when c == delayed expected, else increment fail_cnt, on the same edge as the compare.
REQ-019 SHALL saturate both counters at 2^CNT_W-1; no wrap.
REQ-020 SHALL on the first mismatch after reset or clr set err and load exp_cap/got_cap; later mismatches leave capture regs unchanged.
REQ-021 SHALL give clr priority over a same-cycle compare: counters, err and captures go to 0 and that compare is discarded; pipeline and FSM state unaffected, except HALT -> CHECK.
REQ-022 SHALL register all outputs; compare result is visible one cycle after c is sampled.

Reset
REQ-023 SHALL on reset=0 at a clk edge zero pass_cnt, fail_cnt, err, exp_cap, got_cap and all pipeline stages, and set state=IDLE.
REQ-024 SHALL treat reset asserted mid-stream as a flush: in-flight expectations are discarded and never compared.
REQ-025 SHALL ignore valid_in and clr while reset=0.

Configuration
REQ-026 SHALL compile the halt feature only when macro ADD_CHECKER_HALT_ON_FAIL_EN is defined.
REQ-027 SHALL, with the macro, move CHECK -> HALT on the first mismatch; HALT freezes counters and captures until clr or reset.
REQ-028 SHALL, without the macro, never enter HALT; checking continues after mismatches and state never equals 3.

Structure
REQ-029 SHALL place state encodings (IDLE/WARM/CHECK/HALT) and default WIDTH/LAT/CNT_W constants in shared package add_chk_pkg.
REQ-030 SHALL implement the LAT-stage valid/expected pipeline as sub-module add_chk_delay (parameters WIDTH, LAT; clk, reset ports).

Verification
REQ-031 SHALL cover: LAT=1, a=4,b=7 then a=8,b=17 with c=11, c=25 one cycle later -> pass_cnt=2, fail_cnt=0, err=0, state=CHECK.
REQ-032 SHALL cover: a=200,b=100, c=44 -> pass (wrap-around); c=300 truncated (44) in the same case also passes.
REQ-033 SHALL cover: a=5,b=9 with c forced 13 -> fail_cnt=1, err=1, exp_cap=14, got_cap=13; second mismatch 1+1 vs 3 leaves captures at 14/13.
REQ-034 SHALL cover: reset pulsed low one cycle with 2 operands in flight at LAT=3 -> no counts change, state=IDLE.
REQ-035 SHALL cover: clr asserted on the same cycle as a mismatching compare -> fail_cnt=0, err=0.
REQ-036 SHALL cover: with ADD_CHECKER_HALT_ON_FAIL_EN, a mismatch followed by 3 passing operations -> state=HALT, pass_cnt unchanged until clr; without the macro -> pass_cnt +3.

Source files
------------

// File: rtl/add_chk_pkg.sv
// Shared encodings and default sizing for the adder checker.
// Pure declarations; no logic, no latency, no flow control.
package add_chk_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LAT   = 1;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/add_chk_delay.sv
// LAT-stage shift pipeline carrying {valid, expected sum} alongside the adder under test.
// Latency LAT cycles; no backpressure, synchronous active-low reset flushes every stage.
module add_chk_delay
    import add_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vld,
    input  logic [WIDTH-1:0] exp_dat,
    output logic             dly_vld,
    output logic [WIDTH-1:0] dly_dat
);

    logic [LAT-1:0]   vld_q;
    logic [WIDTH-1:0] dat_q [LAT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld;
            dat_q[0] <= exp_dat;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign dly_vld = vld_q[LAT-1];
    assign dly_dat = dat_q[LAT-1];

endmodule

// File: rtl/add_checker.sv
// Adder checker: compares c against (a+b) mod 2^WIDTH delayed LAT cycles, counts and captures first miss.
// Results registered one cycle after c; no backpressure. ADD_CHECKER_HALT_ON_FAIL_EN halts on first miss.
module add_checker
    import add_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             clr,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [WIDTH-1:0] exp_cap,
    output logic [WIDTH-1:0] got_cap,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] expected;
    logic             dly_vld;
    logic [WIDTH-1:0] dly_dat;
    logic             cmp_en;
    logic             mismatch;
    logic             halt_trip;

    // Carry is dropped by the WIDTH-bit destination.
    assign expected = a + b;

    add_chk_delay #(
        .WIDTH (WIDTH),
        .LAT   (LAT)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .vld     (valid_in),
        .exp_dat (expected),
        .dly_vld (dly_vld),
        .dly_dat (dly_dat)
    );

    assign cmp_en   = dly_vld && (state_q != HALT);
    assign mismatch = (c != dly_dat);

`ifdef ADD_CHECKER_HALT_ON_FAIL_EN
    assign halt_trip = cmp_en && mismatch && !clr;
`else
    assign halt_trip = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (valid_in) state_nxt = WARM;
            end
            WARM: begin
                if (halt_trip)    state_nxt = HALT;
                else if (dly_vld) state_nxt = CHECK;
            end
            CHECK: begin
                if (halt_trip) state_nxt = HALT;
            end
            HALT: begin
                if (clr) state_nxt = CHECK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            exp_cap  <= '0;
            got_cap  <= '0;
        end else begin
            state_q <= state_nxt;
            // A same-cycle clear wins and the pending compare is dropped.
            if (clr) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
                err      <= 1'b0;
                exp_cap  <= '0;
                got_cap  <= '0;
            end else if (cmp_en) begin
                if (mismatch) begin
                    if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                    if (!err) begin
                        err     <= 1'b1;
                        exp_cap <= dly_dat;
                        got_cap <= c;
                    end
                end else if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_add_checker.sv
// Two checkers (LAT=1/CNT_W=16 and LAT=3/CNT_W=4) share one stimulus stream; a cycle-tagged
// scoreboard queue is filled by the stimulus-side reference model and drained by a monitor.
module tb_add_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid_in;
    logic        clr;
    logic [7:0]  a, b, c0, c1;
    logic [15:0] pass0, fail0;
    logic [3:0]  pass1, fail1;
    logic        err0, err1;
    logic [7:0]  ec0, gc0, ec1, gc1;
    logic [1:0]  st0, st1;

    add_checker #(.WIDTH(8), .LAT(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .a(a), .b(b), .c(c0), .clr(clr),
        .pass_cnt(pass0), .fail_cnt(fail0), .err(err0), .exp_cap(ec0), .got_cap(gc0), .state(st0)
    );

    add_checker #(.WIDTH(8), .LAT(3), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .a(a), .b(b), .c(c1), .clr(clr),
        .pass_cnt(pass1), .fail_cnt(fail1), .err(err1), .exp_cap(ec1), .got_cap(gc1), .state(st1)
    );

    typedef struct {
        int cyc;
        int inst;
        int pass;
        int fail;
        int err;
        int ec;
        int gc;
        int st;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Issued-operation history indexed by the edge that sampled it.
    int hist_vld [4096];
    int hist_sum [4096];
    int hist_c   [4096];
    int last_rst = -1;

    int lat_of [2] = '{1, 3};
    int max_of [2] = '{65535, 15};
    int m_pass [2];
    int m_fail [2];
    int m_err  [2];
    int m_ec   [2];
    int m_gc   [2];
    bit m_seen_v [2];
    bit m_seen_c [2];
    bit m_halt   [2];

    task automatic chk(input string nm, input int inst, input int cyc, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s inst%0d cyc=%0d got=%0d want=%0d", nm, inst, cyc, got, want);
        end
    endtask

    // Drive one cycle of inputs, advance the model to the state after that edge, queue expectation.
    task automatic step(input bit vld, input int av, input int bv, input int cv,
                        input bit clr_v, input bit rst_v);
        int   n, k, cval;
        bit   due;
        exp_t e;
        n        = edge_n + 1;
        reset    = !rst_v;
        valid_in = vld;
        clr      = clr_v;
        a        = av[7:0];
        b        = bv[7:0];
        hist_vld[n] = vld ? 1 : 0;
        hist_sum[n] = (av + bv) % 256;
        hist_c[n]   = cv;
        for (int i = 0; i < 2; i++) begin
            k    = n - lat_of[i];
            cval = (k >= 0 && hist_vld[k] == 1) ? hist_c[k] : int'($urandom_range(0, 255));
            if (i == 0) c0 = cval[7:0];
            else        c1 = cval[7:0];
            if (rst_v) begin
                m_pass[i] = 0; m_fail[i] = 0; m_err[i] = 0; m_ec[i] = 0; m_gc[i] = 0;
                m_seen_v[i] = 0; m_seen_c[i] = 0; m_halt[i] = 0;
            end else begin
                due = (k >= 0) && (hist_vld[k] == 1) && (last_rst < k);
                if (clr_v) begin
                    m_pass[i] = 0; m_fail[i] = 0; m_err[i] = 0; m_ec[i] = 0; m_gc[i] = 0;
                    m_halt[i] = 0;
                end else if (due && !m_halt[i]) begin
                    if (cval == hist_sum[k]) begin
                        if (m_pass[i] < max_of[i]) m_pass[i]++;
                    end else begin
                        if (m_fail[i] < max_of[i]) m_fail[i]++;
                        if (m_err[i] == 0) begin
                            m_err[i] = 1; m_ec[i] = hist_sum[k]; m_gc[i] = cval;
                        end
`ifdef ADD_CHECKER_HALT_ON_FAIL_EN
                        m_halt[i] = 1;
`endif
                    end
                end
                if (due) m_seen_c[i] = 1;
                if (vld) m_seen_v[i] = 1;
            end
            e.cyc  = n;
            e.inst = i;
            e.pass = m_pass[i];
            e.fail = m_fail[i];
            e.err  = m_err[i];
            e.ec   = m_ec[i];
            e.gc   = m_gc[i];
            e.st   = m_halt[i] ? 3 : m_seen_c[i] ? 2 : m_seen_v[i] ? 1 : 0;
            sbq.push_back(e);
        end
        if (rst_v) last_rst = n;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int av, input int bv, input int cv);
        step(1'b1, av, bv, cv, 1'b0, 1'b0);
    endtask

    task automatic idle(input int cycles);
        for (int j = 0; j < cycles; j++)
            step(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic do_rst();
        step(1'b1, 3, 4, 7, 1'b0, 1'b1);
    endtask

    // Monitor: compare every queued expectation at the negedge following its edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= edge_n) begin
                e = sbq.pop_front();
                if (e.cyc < edge_n) begin
                    chk("stale_expectation", e.inst, e.cyc, edge_n, e.cyc);
                end else if (e.inst == 0) begin
                    chk("pass_cnt", 0, e.cyc, int'(pass0), e.pass);
                    chk("fail_cnt", 0, e.cyc, int'(fail0), e.fail);
                    chk("err",      0, e.cyc, int'(err0),  e.err);
                    chk("exp_cap",  0, e.cyc, int'(ec0),   e.ec);
                    chk("got_cap",  0, e.cyc, int'(gc0),   e.gc);
                    chk("state",    0, e.cyc, int'(st0),   e.st);
                end else begin
                    chk("pass_cnt", 1, e.cyc, int'(pass1), e.pass);
                    chk("fail_cnt", 1, e.cyc, int'(fail1), e.fail);
                    chk("err",      1, e.cyc, int'(err1),  e.err);
                    chk("exp_cap",  1, e.cyc, int'(ec1),   e.ec);
                    chk("got_cap",  1, e.cyc, int'(gc1),   e.gc);
                    chk("state",    1, e.cyc, int'(st1),   e.st);
                end
            end
        end
    end

    initial begin
        int r, av, bv, sum, cv;
        bit vld, clr_v, rst_v;
        reset = 1'b0; valid_in = 1'b0; clr = 1'b0;
        a = '0; b = '0; c0 = '0; c1 = '0;

        do_rst();
        do_rst();
        idle(2);

        // Two matching sums back to back.
        op(4, 7, 11);
        op(8, 17, 25);
        idle(4);

        // Wrap-around: 200+100 expects 44; 300 truncated to 8 bits is also 44.
        op(200, 100, 44);
        op(200, 100, 300 % 256);
        idle(4);

        // First mismatch captured, second mismatch leaves captures alone.
        op(5, 9, 13);
        op(1, 1, 3);
        idle(4);

        // Clear lands on each instance's mismatching compare edge.
        do_rst();
        op(10, 20, 31);
        do_clr();
        idle(1);
        do_clr();
        idle(3);

        // Mismatch then three good operations, then clear.
        op(6, 6, 13);
        op(1, 2, 3);
        op(50, 60, 110);
        op(255, 1, 0);
        idle(4);
        do_clr();
        idle(2);
        op(9, 9, 18);
        idle(4);

        // Reset pulse with two operations in flight.
        op(2, 3, 5);
        op(4, 4, 8);
        do_rst();
        idle(5);

        for (int t = 0; t < 400; t++) begin
            r     = int'($urandom_range(0, 99));
            rst_v = (r < 2);
            clr_v = (r >= 2 && r < 5);
            vld   = ($urandom_range(0, 99) < 70);
            av    = int'($urandom_range(0, 255));
            bv    = int'($urandom_range(0, 255));
            sum   = (av + bv) % 256;
            cv    = ($urandom_range(0, 99) < 20) ? (sum + 1 + int'($urandom_range(0, 254))) % 256 : sum;
            step(vld, av, bv, cv, clr_v, rst_v);
        end

        idle(6);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 0, edge_n, sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
